// File: rtl/t05_cb_writer.sv
// Codebook writer: packs one header word plus the needed data words
// for each incoming code and writes them into codebook memory.
module t05_cb_writer #(
   parameter int ADDR_W      = 16,
   parameter int BASE_ADDR   = 0,
   parameter int ENTRY_WORDS = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              char_found,
   input  logic [7:0]        char_index,
   input  logic [127:0]      char_path,
   input  logic              finished,
   input  logic              mem_busy,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              write_finish,
   output logic              cb_done,
   output logic [8:0]        char_count,
   output logic              overrun,
   output logic              bad_path
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_HDR,
      S_DATA,
      S_FIN
   } state_t;

   state_t            state;
   logic [7:0]        idx_q;
   logic [127:0]      path_q;
   logic [2:0]        nwords_q;
   logic [1:0]        beat;
   logic [1:0]        beat_nx;
   logic [ADDR_W-1:0] entry_q;
   logic              bad_cur;

   logic [6:0]        len_c;
   logic [2:0]        nw_c;
   logic [ADDR_W-1:0] entry_c;

   // Code length is the position of the leading control bit.
   always_comb begin
      len_c = '0;
      for (int i = 1; i < 128; i++)
         if (path_q[i]) len_c = 7'(i);
   end

   assign nw_c    = 3'((8'(len_c) + 8'd31) >> 5);
   assign entry_c = ADDR_W'(BASE_ADDR)
                  + ADDR_W'(idx_q) * ADDR_W'(ENTRY_WORDS);
   assign beat_nx = beat + 2'd1;

   // Sequencer: latch code, size it, then emit header and data beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         idx_q        <= '0;
         path_q       <= '0;
         nwords_q     <= '0;
         beat         <= '0;
         entry_q      <= '0;
         bad_cur      <= 1'b0;
         mem_wr_en    <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         write_finish <= 1'b0;
         cb_done      <= 1'b0;
         char_count   <= '0;
         overrun      <= 1'b0;
         bad_path     <= 1'b0;
      end else begin
         if (char_found && state != S_IDLE)
            overrun <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (char_found) begin
                  idx_q  <= char_index;
                  path_q <= char_path;
                  state  <= S_LEN;
               end else if (finished) begin
                  cb_done <= 1'b1;
               end
            end
            S_LEN: begin
               if (len_c == 7'd0) begin
                  bad_path     <= 1'b1;
                  bad_cur      <= 1'b1;
                  write_finish <= 1'b1;
                  state        <= S_FIN;
               end else begin
                  path_q[len_c] <= 1'b0;
                  nwords_q      <= nw_c;
                  entry_q       <= entry_c;
                  mem_wr_en     <= 1'b1;
                  mem_addr      <= entry_c;
                  mem_wdata     <= {16'b0, 1'b1, len_c, idx_q};
                  state         <= S_HDR;
               end
            end
            S_HDR: begin
               if (!mem_busy) begin
                  beat      <= '0;
                  mem_addr  <= entry_q + ADDR_W'(1);
                  mem_wdata <= path_q[31:0];
                  state     <= S_DATA;
               end
            end
            S_DATA: begin
               if (!mem_busy) begin
                  if ({1'b0, beat} == nwords_q - 3'd1) begin
                     mem_wr_en    <= 1'b0;
                     write_finish <= 1'b1;
                     state        <= S_FIN;
                  end else begin
                     beat      <= beat_nx;
                     mem_addr  <= entry_q + ADDR_W'(2)
                                + ADDR_W'(beat);
                     mem_wdata <= path_q[{beat_nx, 5'd0} +: 32];
                  end
               end
            end
            S_FIN: begin
               write_finish <= 1'b0;
               if (!bad_cur && char_count != 9'd511)
                  char_count <= char_count + 9'd1;
               bad_cur <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_t05_cb_writer.sv
// Directed bench for the codebook writer: logs accepted writes
// and compares them against hand-computed entries.
module tb_t05_cb_writer;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         char_found = 1'b0;
   logic [7:0]   char_index = '0;
   logic [127:0] char_path = '0;
   logic         finished = 1'b0;
   logic         mem_busy = 1'b0;
   logic         mem_wr_en;
   logic [15:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         write_finish;
   logic         cb_done;
   logic [8:0]   char_count;
   logic         overrun;
   logic         bad_path;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] la[$];
   logic [31:0] ld[$];
   int          wf_cnt = 0;
   int          stall_err = 0;
   logic        p_stall = 1'b0;
   logic [15:0] p_addr;
   logic [31:0] p_data;

   t05_cb_writer dut (
      .clk(clk), .rst(rst),
      .char_found(char_found), .char_index(char_index),
      .char_path(char_path), .finished(finished),
      .mem_busy(mem_busy), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .write_finish(write_finish), .cb_done(cb_done),
      .char_count(char_count), .overrun(overrun),
      .bad_path(bad_path)
   );

   always #5 clk = ~clk;

   // Log accepted beats, finish pulses and stall stability.
   always @(posedge clk) begin
      if (!rst) begin
         if (mem_wr_en && !mem_busy) begin
            la.push_back(mem_addr);
            ld.push_back(mem_wdata);
         end
         if (write_finish) wf_cnt++;
         if (p_stall && (!mem_wr_en || mem_addr != p_addr
                         || mem_wdata != p_data))
            stall_err++;
         p_stall = mem_wr_en && mem_busy;
         p_addr  = mem_addr;
         p_data  = mem_wdata;
      end else begin
         p_stall = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] idx, input logic [127:0] p);
      char_index = idx;
      char_path  = p;
      char_found = 1'b1;
      @(posedge clk);
      #1 char_found = 1'b0;
   endtask

   task automatic wait_wr(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (mem_wr_en) ok = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_log(input string tag, input int pos,
                          input logic [15:0] a, input logic [31:0] d);
      if (pos < la.size()) begin
         chk({tag, "_addr"}, 128'(la[pos]), 128'(a));
         chk({tag, "_data"}, 128'(ld[pos]), 128'(d));
      end else begin
         chk({tag, "_missing"}, 128'(la.size()), 128'(pos + 1));
      end
   endtask

   initial begin
      int  b;
      int  w;
      int  fin_cyc;
      bit  ok;
      logic [127:0] p;

      repeat (3) @(negedge clk);
      chk("rst_wr_en", 128'(mem_wr_en), 128'(0));
      chk("rst_count", 128'(char_count), 128'(0));
      chk("rst_flags", 128'({write_finish, cb_done, overrun, bad_path}),
          128'(0));
      rst = 1'b0;
      idle(2);

      // 1: len 3, index 0x41, latency check
      b = la.size(); w = wf_cnt;
      @(negedge clk);
      send(8'h41, 128'b1010);
      fin_cyc = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 2) begin
            chk("t1_hdr_en", 128'(mem_wr_en), 128'(1));
            chk("t1_hdr_addr", 128'(mem_addr), 128'h145);
         end
         if (write_finish && fin_cyc < 0) fin_cyc = c;
      end
      chk("t1_fin_cycle", 128'(fin_cyc), 128'(4));
      chk("t1_nwr", 128'(la.size() - b), 128'(2));
      chk_log("t1_hdr", b, 16'h0145, 32'h0000_8341);
      chk_log("t1_d0", b + 1, 16'h0146, 32'h0000_0002);
      chk("t1_wf", 128'(wf_cnt - w), 128'(1));
      chk("t1_count", 128'(char_count), 128'(1));

      // 2: len 64 with 3 stall cycles on each beat
      b = la.size(); w = wf_cnt;
      mem_busy = 1'b1;
      p = '0;
      p[64] = 1'b1;
      p[63:0] = 64'hDEAD_BEEF_1234_5678;
      send(8'h02, p);
      for (int k = 0; k < 3; k++) begin
         wait_wr(ok);
         if (!ok) chk("t2_wr_timeout", 128'(0), 128'(1));
         idle(3);
         mem_busy = 1'b0;
         @(negedge clk);
         mem_busy = 1'b1;
      end
      mem_busy = 1'b0;
      idle(6);
      chk("t2_nwr", 128'(la.size() - b), 128'(3));
      chk_log("t2_hdr", b, 16'd10, 32'h0000_C002);
      chk_log("t2_d0", b + 1, 16'd11, 32'h1234_5678);
      chk_log("t2_d1", b + 2, 16'd12, 32'hDEAD_BEEF);
      chk("t2_stable", 128'(stall_err), 128'(0));
      chk("t2_wf", 128'(wf_cnt - w), 128'(1));
      chk("t2_count", 128'(char_count), 128'(2));

      // 3: len 127, four data words, control bit stripped
      b = la.size(); w = wf_cnt;
      p = {32'hC000_0001, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      send(8'hFF, p);
      idle(12);
      chk("t3_nwr", 128'(la.size() - b), 128'(5));
      chk_log("t3_hdr", b, 16'h04FB, 32'h0000_FFFF);
      chk_log("t3_d0", b + 1, 16'h04FC, 32'h1111_1111);
      chk_log("t3_d1", b + 2, 16'h04FD, 32'h2222_2222);
      chk_log("t3_d2", b + 3, 16'h04FE, 32'h3333_3333);
      chk_log("t3_d3", b + 4, 16'h04FF, 32'h4000_0001);
      chk("t3_count", 128'(char_count), 128'(3));

      // 4: empty code
      b = la.size(); w = wf_cnt;
      chk("t4_bad_pre", 128'(bad_path), 128'(0));
      send(8'h07, 128'b1);
      idle(8);
      chk("t4_bad", 128'(bad_path), 128'(1));
      chk("t4_nwr", 128'(la.size() - b), 128'(0));
      chk("t4_wf", 128'(wf_cnt - w), 128'(1));
      chk("t4_count", 128'(char_count), 128'(3));

      // 5: second code arrives during DATA
      b = la.size(); w = wf_cnt;
      p = '0;
      p[40] = 1'b1;
      p[39:0] = 40'hAB_CDEF_0123;
      send(8'h03, p);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (mem_wr_en && mem_addr == 16'd16) ok = 1'b1;
      end
      chk("t5_in_data", 128'(ok), 128'(1));
      send(8'h09, 128'b1_1111);
      idle(10);
      chk("t5_overrun", 128'(overrun), 128'(1));
      chk("t5_nwr", 128'(la.size() - b), 128'(3));
      chk_log("t5_hdr", b, 16'd15, 32'h0000_A803);
      chk_log("t5_d0", b + 1, 16'd16, 32'hCDEF_0123);
      chk_log("t5_d1", b + 2, 16'd17, 32'h0000_00AB);
      chk("t5_wf", 128'(wf_cnt - w), 128'(1));
      chk("t5_count", 128'(char_count), 128'(4));

      // 6: finished while idle, then reset during a header stall
      chk("t6_done_pre", 128'(cb_done), 128'(0));
      finished = 1'b1;
      @(negedge clk);
      finished = 1'b0;
      idle(1);
      chk("t6_done", 128'(cb_done), 128'(1));
      mem_busy = 1'b1;
      send(8'h01, 128'b1_0110);
      wait_wr(ok);
      chk("t6_hdr_seen", 128'(ok), 128'(1));
      idle(2);
      rst = 1'b1;
      #1;
      chk("t6_rst_wr_en", 128'(mem_wr_en), 128'(0));
      chk("t6_rst_addr", 128'(mem_addr), 128'(0));
      chk("t6_rst_data", 128'(mem_wdata), 128'(0));
      chk("t6_rst_count", 128'(char_count), 128'(0));
      chk("t6_rst_flags",
          128'({write_finish, cb_done, overrun, bad_path}), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
